// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit and the ALU it drives:
// ALU operation codes, opcode/funct constants, datapath mux selects and FSM states.
package mips_pkg;

  localparam logic [4:0] ALU_SUM = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00011;
  localparam logic [4:0] ALU_SL  = 5'b00100;
  localparam logic [4:0] ALU_SRL = 5'b00101;
  localparam logic [4:0] ALU_SRA = 5'b00110;
  localparam logic [4:0] ALU_LUI = 5'b00111;
  localparam logic [4:0] ALU_ORI = 5'b01000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;

  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_A   = 2'b01;
  localparam logic [1:0] SRCA_IMM = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_IMM_EX   = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational op/funct decode into the ALU operation, a shift flag (shamt
// operand path) and a valid flag for supported encodings.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [4:0] alu_control,
  output logic       is_shift,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_SUM;
    is_shift    = 1'b0;
    valid       = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: valid = 1'b1;
          F_OR: begin
            alu_control = ALU_OR;
            valid       = 1'b1;
          end
          F_AND: begin
            alu_control = ALU_AND;
            valid       = 1'b1;
          end
          F_SLL: begin
            alu_control = ALU_SL;
            is_shift    = 1'b1;
            valid       = 1'b1;
          end
          F_SRL: begin
            alu_control = ALU_SRL;
            is_shift    = 1'b1;
            valid       = 1'b1;
          end
          F_SRA: begin
            alu_control = ALU_SRA;
            is_shift    = 1'b1;
            valid       = 1'b1;
          end
          default: valid = 1'b0;
        endcase
      end
      OP_ORI: begin
        alu_control = ALU_ORI;
        valid       = 1'b1;
      end
      OP_LUI: begin
        alu_control = ALU_LUI;
        valid       = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: valid = 1'b1;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: Moore outputs from the current state plus the
// stable IR fields, with a sticky flag for unsupported encodings.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       rs_eq_rt,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [4:0] ALUControl,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [4:0] dec_alu;
  logic       dec_shift;
  logic       dec_valid;

  // The branch condition is combined with Branch in the datapath, never here.
  logic unused_rs_eq_rt;
  assign unused_rs_eq_rt = rs_eq_rt;

  alu_decoder u_alu_decoder (
    .op          (op),
    .funct       (funct),
    .alu_control (dec_alu),
    .is_shift    (dec_shift),
    .valid       (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) begin
          state_d = S_MEMADR;
        end else if (op == OP_RTYPE) begin
          state_d = S_RTYPE_EX;
        end else if (is_imm_op(op)) begin
          state_d = S_IMM_EX;
        end else if (op == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (op == OP_J) begin
          state_d = S_JUMP;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTYPE_EX: begin
        if (dec_valid) begin
          state_d = S_RTYPE_WB;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_IMM_EX: state_d = S_IMM_WB;
      S_MEMWB, S_MEMWR, S_RTYPE_WB, S_IMM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    PCSrc      = PCSRC_ALU;
    ALUControl = ALU_SUM;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA    = dec_shift ? SRCA_IMM : SRCA_A;
        ALUControl = dec_alu;
      end
      // Write-back states keep the EX-stage ALU code; op/funct are still stable.
      S_RTYPE_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        ALUControl = dec_alu;
      end
      S_IMM_EX: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_alu;
      end
      S_IMM_WB: begin
        RegWrite   = 1'b1;
        ALUControl = dec_alu;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_A;
        Branch  = 1'b1;
        PCSrc   = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      default: ALUControl = ALU_SUM;
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle control unit for the 32-bit MIPS core: a Moore FSM that decodes `op`/`funct` from the instruction register and drives every datapath mux/enable, including the 5-bit `ALUControl` consumed by the ALU. Sits beside the datapath, one instruction at a time, 3–5 cycles per instruction. Also flags unsupported encodings.

## Interface
Parameters:
- none (all encodings fixed in shared package)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces FETCH on the next edge
- op  in  6  instruction [31:26] from the instruction register
- funct  in  6  instruction [5:0]
- rs_eq_rt  in  1  equality flag from datapath comparator (A == B)
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load qualified by rs_eq_rt (PC enable = PCWrite | (Branch & rs_eq_rt))
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemtoReg  out  1  write data: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  2  00 = PC, 01 = A, 10 = sign-extended imm (shamt lands in bits [10:6])
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 2'b00}
- ALUControl  out  5  SUM 00000, OR 00001, AND 00011, SL 00100, SRL 00101, SRA 00110, LUI 00111, ORI 01000
- illegal  out  1  sticky; set on unsupported encoding, cleared only by reset

## Operation
- Supported: R-type (op 000000) funct add 100000/addu 100001 → SUM, or 100101 → OR, and 100100 → AND, sll 000000 → SL, srl 000010 → SRL, sra 000011 → SRA; lw 100011, sw 101011, addi 001000/addiu 001001 (SUM), ori 001101 (ORI), lui 001111 (LUI), beq 000100, j 000010. No overflow traps.
- States and asserted outputs (unlisted outputs 0, ALUControl SUM):
  - FETCH: IRWrite, ALUSrcA=00, ALUSrcB=01, PCSrc=00, PCWrite → DECODE
  - DECODE: ALUSrcA=00, ALUSrcB=11 (branch target to ALUOut) → by op: lw/sw→MEMADR, R-type→RTYPE_EX, addi/addiu/ori/lui→IMM_EX, beq→BRANCH, j→JUMP, else→FETCH and set illegal
  - MEMADR: ALUSrcA=01, ALUSrcB=10 → lw: MEMRD, sw: MEMWR
  - MEMRD: IorD → MEMWB
  - MEMWB: RegWrite, MemtoReg, RegDst=0 → FETCH
  - MEMWR: IorD, MemWrite → FETCH
  - RTYPE_EX: ALUSrcB=00; ALUSrcA=10 for sll/srl/sra, 01 otherwise; ALUControl from funct → RTYPE_WB; unknown funct → FETCH, set illegal, no write
  - RTYPE_WB: RegWrite, RegDst=1, MemtoReg=0 → FETCH
  - IMM_EX: ALUSrcA=01, ALUSrcB=10, ALUControl SUM/ORI/LUI by op → IMM_WB
  - IMM_WB: RegWrite, RegDst=0, MemtoReg=0 → FETCH
  - BRANCH: ALUSrcA=01, ALUSrcB=00, Branch, PCSrc=01 → FETCH
  - JUMP: PCWrite, PCSrc=10 → FETCH
- Outputs are pure functions of state plus registered op/funct (IR-stable after FETCH); no output depends combinationally on rs_eq_rt.
- In RTYPE_WB/IMM_WB, ALUControl holds the EX-state value (ALUOut already latched; holding keeps waveforms clean).

## Timing
- Reset: state = FETCH, illegal = 0; FETCH outputs visible the cycle after reset deasserts (IRWrite=1, PCWrite=1).
- Reset asserted mid-instruction: next edge returns to FETCH, no further RegWrite/MemWrite from the aborted instruction.
- Cycles per instruction: lw 5, sw/R-type/imm 4, beq/j 3, illegal 2.
- Exactly one cycle of MemWrite per sw, one of RegWrite per lw/R/imm, one PC load per FETCH plus at most one in BRANCH/JUMP.
- illegal sets on the edge leaving DECODE/RTYPE_EX; persists through subsequent instructions.

## Structure
- Shared package `mips_pkg`: ALUControl encodings (shared with ALU), opcode/funct constants, ALUSrcA/ALUSrcB/PCSrc select encodings, state enum.
- Natural sub-module: `alu_decoder` (combinational funct/op → ALUControl + is_shift + valid), instantiated by the FSM.

## Test plan
- Reset held 3 cycles then released, op=000000 funct=100001 → states FETCH,DECODE,RTYPE_EX,RTYPE_WB,FETCH; ALUControl 00000 in EX; RegWrite=1, RegDst=1 only in cycle 4.
- sll (funct 000000) → RTYPE_EX ALUSrcA=10, ALUSrcB=00, ALUControl 00100; sra → 00110.
- lw (100011) → 5 cycles, IorD=1 in MEMRD, MemtoReg=1/RegWrite=1 in MEMWB; sw (101011) → 4 cycles, single MemWrite pulse, no RegWrite.
- beq with rs_eq_rt=1 then 0 → BRANCH asserts Branch=1, PCSrc=01 both times; PC enable high only when equal; 3 cycles.
- ori/lui/j → ALUControl 01000 / 00111 in IMM_EX; j asserts PCWrite, PCSrc=10 in JUMP.
- op=111111, then reset asserted during MEMRD of a lw → illegal=1 after DECODE, FETCH next; reset clears illegal, no RegWrite emitted.
